// File: rtl/sobel_window_gen.sv
// Builds a 3x3 pixel window for Sobel filtering from a raster pixel stream.
// Two line buffers hold the previous two lines; the window shifts one column per accepted pixel.
module sobel_window_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pixel_in,
  input  logic       pixel_valid,
  input  logic       sof,
  output logic [7:0] P0,
  output logic [7:0] P1,
  output logic [7:0] P2,
  output logic [7:0] P3,
  output logic [7:0] P4,
  output logic [7:0] P5,
  output logic [7:0] P6,
  output logic [7:0] P7,
  output logic [7:0] P8,
  output logic       start_calculations,
  output logic       frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_col, w_col;
  logic [RW-1:0] r_row, w_row;
  logic          w_sof, w_accept, w_col_last, w_last_pix, w_win_ok;
  logic [7:0]    w_lb1_rd, w_lb2_rd;
  logic [7:0]    r_lb1 [0:IMG_WIDTH-1];
  logic [7:0]    r_lb2 [0:IMG_WIDTH-1];

  // A qualified sof restarts the frame from any state, so its pixel is always (0,0).
  assign w_sof      = pixel_valid & sof;
  assign w_accept   = w_sof | (pixel_valid & (r_state == S_ACTIVE));
  assign w_col      = w_sof ? '0 : r_col;
  assign w_row      = w_sof ? '0 : r_row;
  assign w_col_last = (w_col == COL_LAST);
  assign w_last_pix = w_col_last && (w_row == ROW_LAST);
  assign w_win_ok   = (w_row >= RW'(2)) && (w_col >= CW'(2));
  assign w_lb1_rd   = r_lb1[w_col];
  assign w_lb2_rd   = r_lb2[w_col];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_sof) w_state_nxt = S_ACTIVE;
      S_ACTIVE: if (w_accept && w_last_pix) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_col   <= '0;
      r_row   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        if (w_last_pix) begin
          r_col <= '0;
          r_row <= '0;
        end else if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row + RW'(1);
        end else begin
          r_col <= w_col + CW'(1);
          r_row <= w_row;
        end
      end
    end
  end

  // NOTE: line buffer RAM has no reset; the first two lines of every frame overwrite it before use.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb2[w_col] <= w_lb1_rd;
      r_lb1[w_col] <= pixel_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {P0, P1, P2, P3, P4, P5, P6, P7, P8} <= '0;
      start_calculations <= 1'b0;
      frame_done         <= 1'b0;
    end else begin
      start_calculations <= w_accept && w_win_ok;
      frame_done         <= w_accept && w_last_pix;
      if (w_accept) begin
        P0 <= P1;  P1 <= P2;  P2 <= w_lb2_rd;
        P3 <= P4;  P4 <= P5;  P5 <= w_lb1_rd;
        P6 <= P7;  P7 <= P8;  P8 <= pixel_in;
      end
    end
  end

endmodule
